// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer_if
//  Description : Control/status bundle between the game control FSM (master)
//                and the countdown timer (slave): start/hold/load in, count,
//                BCD digits and state flags out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface countdown_timer_if #(
    parameter int CNT_W = 7
);
    logic             start;
    logic             hold;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] count;
    logic [3:0]       tens;
    logic [3:0]       ones;
    logic             running;
    logic             done;
    logic             expired;

    // Game control side: issues start/hold, observes the timer.
    modport master (
        output start,
        output hold,
        output load_val,
        input  count,
        input  tens,
        input  ones,
        input  running,
        input  done,
        input  expired
    );

    // Timer side.
    modport slave (
        input  start,
        input  hold,
        input  load_val,
        output count,
        output tens,
        output ones,
        output running,
        output done,
        output expired
    );
endinterface
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Loadable countdown timer with built-in tick prescaler,
//                hold/resume, one-cycle expiry pulse and BCD digit outputs.
//                The count is clamped to 99 so it always fits two digits.
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    countdown_timer_if.slave  tmr
);

    // Clock cycles per countdown tick; must be an integer of at least 2.
    localparam int c_DIV  = CLK_HZ / TICK_HZ;
    localparam int c_PS_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;

    // Prescaler value on which the tick fires.
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(c_DIV - 1);

    // Largest loadable value: 99, or all-ones if the count is too narrow
    // to hold 99 at all.
    localparam logic [CNT_W-1:0] c_MAX_CNT = (CNT_W >= 7) ? CNT_W'(99)
                                                          : {CNT_W{1'b1}};

    localparam logic [CNT_W-1:0]  c_CNT_ONE = CNT_W'(1);
    localparam logic [c_PS_W-1:0] c_PS_ONE  = c_PS_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [c_PS_W-1:0]   r_prescale;
    logic [c_PS_W-1:0]   w_prescale_nxt;
    logic                r_expired;
    logic                w_expired_nxt;

    logic                w_tick;
    logic [CNT_W-1:0]    w_load_clamped;
    logic                w_load_zero;

    logic [6:0]          w_count7;
    logic [3:0]          w_tens;
    logic [3:0]          w_ones;

    // Clamp the requested start value to the two-digit display range.
    always_comb begin
        w_load_clamped = tmr.load_val;
        if (tmr.load_val > c_MAX_CNT) begin
            w_load_clamped = c_MAX_CNT;
        end
        w_load_zero = (w_load_clamped == '0);
    end

    // The tick only exists while actively counting; HOLD freezes the phase.
    assign w_tick = (r_state == S_RUN) && (r_prescale == c_PS_LAST);

    // State, count, prescaler phase and expiry pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_prescale <= '0;
            r_expired  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_prescale <= w_prescale_nxt;
            r_expired  <= w_expired_nxt;
        end
    end

    // Next-state logic: start overrides everything, otherwise count/hold.
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_prescale_nxt = r_prescale;
        w_expired_nxt  = 1'b0;

        if (tmr.start) begin
            // Reload; a zero load expires immediately. hold is ignored here.
            w_count_nxt    = w_load_clamped;
            w_prescale_nxt = '0;
            if (w_load_zero) begin
                w_state_nxt   = S_DONE;
                w_expired_nxt = 1'b1;
            end else begin
                w_state_nxt   = S_RUN;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_tick) begin
                        // A due tick is always applied, even if hold is high;
                        // reaching zero takes precedence over entering HOLD.
                        w_prescale_nxt = '0;
                        if (r_count <= c_CNT_ONE) begin
                            w_count_nxt   = '0;
                            w_state_nxt   = S_DONE;
                            w_expired_nxt = 1'b1;
                        end else begin
                            w_count_nxt = r_count - c_CNT_ONE;
                            if (tmr.hold) begin
                                w_state_nxt = S_HOLD;
                            end
                        end
                    end else if (tmr.hold) begin
                        // Freeze with the prescaler phase retained.
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_prescale_nxt = r_prescale + c_PS_ONE;
                    end
                end
                S_HOLD: begin
                    // The release edge is a normal counting edge, so a hold
                    // of H cycles shifts later ticks by exactly H. The frozen
                    // phase is never the last one, so no tick is due here.
                    if (!tmr.hold) begin
                        w_state_nxt    = S_RUN;
                        w_prescale_nxt = r_prescale + c_PS_ONE;
                    end
                end
                default: begin
                    // IDLE and DONE wait for start.
                end
            endcase
        end
    end

    // BCD split works on a 7-bit view; the count never exceeds 99.
    generate
        if (CNT_W >= 7) begin : g_cnt_wide
            assign w_count7 = r_count[6:0];
        end else begin : g_cnt_narrow
            assign w_count7 = {{(7 - CNT_W){1'b0}}, r_count};
        end
    endgenerate

    // Combinational digit split so digits track count in the same cycle.
    always_comb begin
        w_tens = 4'(w_count7 / 7'd10);
        w_ones = 4'(w_count7 % 7'd10);
    end

    assign tmr.count   = r_count;
    assign tmr.tens    = w_tens;
    assign tmr.ones    = w_ones;
    assign tmr.running = (r_state == S_RUN);
    assign tmr.done    = (r_state == S_DONE);
    assign tmr.expired = r_expired;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Self-checking bench for countdown_timer (DIV = 10). Directed
//                scenarios plus random start/hold/load traffic, compared each
//                cycle against an elapsed-time reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

    localparam int CLK_HZ  = 10;
    localparam int TICK_HZ = 1;
    localparam int CNT_W   = 7;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_mis;

    // Reference model: count = load - floor(active_cycles / DIV).
    int m_load;
    int m_elapsed;
    int m_count;
    bit m_active;
    bit m_held;
    bit m_done;
    bit m_exp;

    countdown_timer_if #(.CNT_W(CNT_W)) ifc ();

    countdown_timer #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tmr   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_load    = 0;
        m_elapsed = 0;
        m_count   = 0;
        m_active  = 1'b0;
        m_held    = 1'b0;
        m_done    = 1'b0;
        m_exp     = 1'b0;
    endtask

    // One clock edge of the model, from the sampled inputs.
    task automatic model_edge(input bit s, input bit h, input int lv);
        bit adv;
        m_exp = 1'b0;
        if (s) begin
            m_load    = (lv > 99) ? 99 : lv;
            m_elapsed = 0;
            m_held    = 1'b0;
            m_count   = m_load;
            m_active  = (m_load != 0);
            m_done    = (m_load == 0);
            m_exp     = m_done;
        end else if (m_active) begin
            // Time advances unless hold freezes it; a due tick is never lost.
            adv = !h || (!m_held && ((m_elapsed + 1) % DIV == 0));
            if (adv) m_elapsed++;
            m_count = m_load - m_elapsed / DIV;
            if (m_count == 0) begin
                m_active = 1'b0;
                m_held   = 1'b0;
                m_done   = 1'b1;
                m_exp    = 1'b1;
            end else begin
                m_held = h;
            end
        end
    endtask

    task automatic compare_all();
        check("count",   32'(ifc.count),   32'(m_count));
        check("tens",    32'(ifc.tens),    32'(m_count / 10));
        check("ones",    32'(ifc.ones),    32'(m_count % 10));
        check("running", 32'(ifc.running), 32'(m_active && !m_held));
        check("done",    32'(ifc.done),    32'(m_done));
        check("expired", 32'(ifc.expired), 32'(m_exp));
    endtask

    // Drive inputs, take one edge, then compare just after it.
    task automatic step(input bit s, input bit h, input int lv);
        ifc.start    = s;
        ifc.hold     = h;
        ifc.load_val = 7'(lv);
        @(posedge clk);
        model_edge(s, h, lv % 128);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
    endtask

    int hold_left;
    bit r_s;
    bit r_h;
    int r_lv;

    initial begin
        n_cmp        = 0;
        n_mis        = 0;
        hold_left    = 0;
        rst_n        = 1'b0;
        ifc.start    = 1'b0;
        ifc.hold     = 1'b0;
        ifc.load_val = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_count",   32'(ifc.count),   32'd0);
        check("rst_running", 32'(ifc.running), 32'd0);
        check("rst_done",    32'(ifc.done),    32'd0);
        check("rst_expired", 32'(ifc.expired), 32'd0);
        rst_n = 1'b1;
        idle(3);

        // Load 3: decrements at edges 10, 20; expires at edge 30.
        step(1'b1, 1'b0, 3);
        check("ld3_e0", 32'(ifc.count), 32'd3);
        for (int i = 1; i <= 31; i++) begin
            step(1'b0, 1'b0, 0);
            if (i == 9)  check("ld3_e9",  32'(ifc.count), 32'd3);
            if (i == 10) check("ld3_e10", 32'(ifc.count), 32'd2);
            if (i == 20) check("ld3_e20", 32'(ifc.count), 32'd1);
            if (i == 29) check("ld3_exp29", 32'(ifc.expired), 32'd0);
            if (i == 30) begin
                check("ld3_e30", 32'(ifc.count), 32'd0);
                check("ld3_exp30", 32'(ifc.expired), 32'd1);
                check("ld3_done30", 32'(ifc.done), 32'd1);
                check("ld3_run30", 32'(ifc.running), 32'd0);
            end
            if (i == 31) check("ld3_exp31", 32'(ifc.expired), 32'd0);
        end

        // 99 and its BCD digits, then one tick.
        step(1'b1, 1'b0, 99);
        check("ld99_tens", 32'(ifc.tens), 32'd9);
        check("ld99_ones", 32'(ifc.ones), 32'd9);
        idle(10);
        check("ld99_cnt98", 32'(ifc.count), 32'd98);
        check("ld99_ones8", 32'(ifc.ones), 32'd8);

        // Clamp and zero load.
        step(1'b1, 1'b0, 120);
        check("clamp120", 32'(ifc.count), 32'd99);
        step(1'b1, 1'b0, 0);
        check("zero_done", 32'(ifc.done), 32'd1);
        check("zero_exp",  32'(ifc.expired), 32'd1);
        idle(12);
        check("zero_cnt", 32'(ifc.count), 32'd0);
        check("zero_exp_end", 32'(ifc.expired), 32'd0);

        // Hold for 7 cycles from cycle 4: first decrement moves to edge 17.
        step(1'b1, 1'b0, 5);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, (i >= 4 && i <= 10), 0);
            if (i == 10) check("hold_e10", 32'(ifc.count), 32'd5);
            if (i == 16) check("hold_e16", 32'(ifc.count), 32'd5);
            if (i == 17) check("hold_e17", 32'(ifc.count), 32'd4);
        end

        // Hold asserted on the tick edge: decrement still happens.
        step(1'b1, 1'b0, 5);
        idle(9);
        step(1'b0, 1'b1, 0);
        check("hold_tick_cnt", 32'(ifc.count), 32'd4);
        check("hold_tick_run", 32'(ifc.running), 32'd0);
        step(1'b0, 1'b1, 0);
        idle(12);

        // Restart mid-count at count=2 with 4: next decrement 10 cycles on.
        step(1'b1, 1'b0, 3);
        idle(10);
        check("rs_at2", 32'(ifc.count), 32'd2);
        step(1'b1, 1'b0, 4);
        idle(9);
        check("rs_e9", 32'(ifc.count), 32'd4);
        idle(1);
        check("rs_e10", 32'(ifc.count), 32'd3);

        // Start from DONE.
        step(1'b1, 1'b0, 1);
        idle(11);
        check("done_before", 32'(ifc.done), 32'd1);
        step(1'b1, 1'b0, 2);
        check("done_clr", 32'(ifc.done), 32'd0);
        check("done_rs_cnt", 32'(ifc.count), 32'd2);
        check("done_rs_run", 32'(ifc.running), 32'd1);

        // Continuous start never decrements.
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 7);
        check("start_held", 32'(ifc.count), 32'd7);

        // Async reset mid-count at count 7, prescaler phase 6.
        step(1'b1, 1'b0, 7);
        idle(6);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_count",   32'(ifc.count),   32'd0);
        check("arst_running", 32'(ifc.running), 32'd0);
        check("arst_done",    32'(ifc.done),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(25);
        check("arst_idle", 32'(ifc.count), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r_s = ($urandom_range(0, 99) < 3);
            if (hold_left > 0) begin
                r_h = 1'b1;
                hold_left--;
            end else begin
                r_h = 1'b0;
                if ($urandom_range(0, 99) < 5) hold_left = int'($urandom_range(1, 15));
            end
            if ($urandom_range(0, 1) == 0) r_lv = int'($urandom_range(0, 12));
            else                           r_lv = int'($urandom_range(0, 127));
            step(r_s, r_h, r_lv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/countdown_timer.md
# countdown_timer

Parametrised countdown timer with an integrated tick prescaler. It is the next-generation replacement for the fixed 30-second game timer. It loads a runtime value, counts down once per tick, and supports hold/resume. It also emits a one-cycle expiry pulse and drives BCD digits straight to the seven-segment display path. It sits between the game control FSM (start/hold) and the display mux.

## Interface
Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- TICK_HZ, 1, countdown rate. DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2.
- CNT_W, 7, count width. The count value is clamped to 99 regardless of width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level sampled each clock; a high sample loads and starts the countdown.
- hold  in  1  level; freezes the countdown while high.
- load_val  in  CNT_W  start value, sampled when start is high.
- count  out  CNT_W  current remaining ticks.
- tens  out  4  BCD tens digit of count.
- ones  out  4  BCD ones digit of count.
- running  out  1  high in RUN state only.
- done  out  1  high in DONE state; replaces the legacy pause flag.
- expired  out  1  one-cycle pulse on entry to DONE.

## Operation
- States: IDLE, RUN, HOLD, DONE. Reset enters IDLE.
- Reset values: count=0, running=0, done=0, expired=0, prescaler=0. tens/ones are therefore 0.
- Clamp rule: the value loaded is min(load_val, 99).
- start has priority over every other input in every state, including mid-count, HOLD and DONE:
  - count ← clamp(load_val); prescaler ← 0; expired ← 0.
  - Next state is RUN if the clamped value is nonzero, or if it is zero, DONE with expired=1 for one cycle.
  - hold is ignored in the start cycle.
- Prescaler runs only in RUN. It counts 0..DIV-1 and generates tick when it equals DIV-1, then wraps to 0.
- RUN:
  - On tick with count>1, count ← count-1.
  - On tick with count==1, count ← 0, go to DONE, expired=1 for one cycle.
  - If hold is high and no tick is due, go to HOLD with the prescaler frozen (phase retained).
  - If hold and tick coincide, the tick is applied first and HOLD is entered on the same edge. If that tick reaches 0, DONE wins.
- HOLD: count and prescaler are frozen. hold low returns to RUN on the next edge, and counting resumes from the retained prescaler phase.
- DONE: count stays 0 and done=1 until start. hold has no effect.
- IDLE: all outputs hold reset values until start.
- Count never underflows; no decrement occurs at 0.
- tens/ones are combinational from count: tens = count/10, ones = count%10. They are valid in the same cycle as count.

## Timing
- start sampled high at edge k:
  - count, running and done update at edge k and are visible after k.
  - First decrement at edge k+DIV.
  - Each following decrement comes DIV cycles after the previous one, provided hold stays low.
- Load N (1..99) with no hold: done rises and expired pulses at edge k+N·DIV. expired is high for exactly one clock.
- A HOLD of H cycles delays every subsequent decrement by exactly H cycles.
- rst_n asserted low at any time: all state returns to reset values immediately, without waiting for clk. Deassertion is synchronised externally; the block needs no first-edge special case.
- start held high continuously: the timer reloads every cycle and never decrements.

## Test plan
Bench uses CLK_HZ=10, TICK_HZ=1, so DIV=10.
- Reset, then start pulse with load_val=3 at edge 0:
  - count reads 3 immediately, then 2 at edge 10 and 1 at edge 20.
  - count reaches 0 at edge 30 with expired high for that cycle only; done=1 and running=0 from then on.
- load_val=99: count=99, tens=9, ones=9. After one tick, count=98, tens=9, ones=8.
- Clamping and zero load:
  - load_val=120 gives count=99.
  - load_val=0 goes straight to DONE with a single expired pulse and no decrements.
- Hold:
  - load_val=5, hold high for 7 cycles starting at cycle 4: the first decrement moves from edge 10 to edge 17, and count stays 5 throughout the hold.
  - hold asserted on a tick cycle: the decrement is still applied.
- Restart:
  - start during RUN at count=2 reloads to load_val=4, and the next decrement comes 10 cycles later.
  - start in DONE restarts the countdown and clears done.
- rst_n driven low mid-count with count=7 and a prescaler phase of 6: count=0, running=0, done=0 asynchronously. After release, the timer stays in IDLE until start.
